seg_scroller: RTL and testbench
===============================

Name: seg_scroller

Overview:
- Upstream stage of the eight-digit seg tube scanner.
- Holds a 16-character message buffer and decodes character codes to active-low segment patterns.
- Presents an 8-digit window, either static or scrolling as a marquee, on eight parallel 8-bit outputs.
- Outputs o0..o7 connect directly to the scanner's i0..i7; o0 is the leftmost digit.

Parameters:
- STEP_CYCLES, 25000000: clk cycles per scroll step (0.25 s at 100 MHz); minimum 2.
- BLINK_CYCLES, 50000000: half-period of the blink phase in clk cycles; used only with SEG_SCROLL_BLINK_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- wr_en  input  1  buffer write strobe; writes on a clk edge while high
- wr_addr  input  4  buffer entry 0..15
- wr_data  input  6  {dp, code[4:0]}
- msg_len  input  4  message length, sampled on command; 0 means 16
- cmd_show  input  1  enter static display
- cmd_scroll  input  1  enter marquee scroll
- cmd_stop  input  1  return to idle
- blink_mask  input  8  per-digit blink enable; bit k maps to ok
- o0..o7  output  8 each  segment patterns {a,b,c,d,e,f,g,dp}, active-low
- busy  output  1  high when not IDLE
- wrap  output  1  one-cycle pulse when the scroll offset wraps to 0

Behaviour:
- Reset:
  - State is IDLE.
  - All buffer entries are cleared to 6'b0_10000 (blank, dp off).
  - o0..o7 = 8'hFF; busy = 0; wrap = 0; offset = 0; prescaler = 0; len_q = 16.
- Character decode (bit 0 = dp, active-low; dp set clears bit 0):
  - Hex digits 0..F: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71.
  - 0x10 = blank FF; 0x11 '-' = FD; 0x12 'P' = 31; 0x13 'L' = E3; 0x14 'H' = 91; 0x15 'U' = 83; 0x16 'r' = F5; 0x17 'o' = C5.
  - Codes 0x18..0x1F decode as blank FF, and dp still applies.
- Commands:
  - Priority when asserted together: cmd_stop > cmd_scroll > cmd_show.
  - cmd_show or cmd_scroll latches len_q = (msg_len==0 ? 16 : msg_len), resets offset to 0 and resets the prescaler to 0, from any state including the same state (a restart).
- FSM states:
  - IDLE: o0..o7 = FF.
  - SHOW: digit k shows buf[k] if k < len_q, else FF. Offset is frozen.
  - SCROLL: uses a virtual sequence v of period P = len_q + 8. v[j] = buf[j] for j < len_q; v[j] = blank for len_q ≤ j < P.
    - Digit k shows v[(offset + k) mod P].
    - The prescaler counts 0..STEP_CYCLES-1. On the cycle it equals STEP_CYCLES-1, it returns to 0 and offset advances by 1.
    - Offset P-1 → 0 wraps; wrap is asserted for exactly the cycle after that edge.
    - The first frame after cmd_scroll shows blanks on the digits beyond len_q; the message then moves left.
  - Transitions: cmd_stop → IDLE from any state. cmd_scroll → SCROLL. cmd_show → SHOW.
- Timing:
  - Outputs are registered: o0..o7 reflect the state, buffer, and offset as of the previous clk edge (1-cycle latency).
  - A write at edge N is visible on the outputs after edge N+1.
  - Writes are accepted in every state, including mid-scroll, and take effect immediately in the window.
  - msg_len changes without a command are ignored.
- Reset mid-scroll: rst wins over all commands and writes in the same cycle.

Optional Feature:
- Macro SEG_SCROLL_BLINK_EN.
- When defined:
  - A blink counter toggles a phase bit every BLINK_CYCLES cycles; it runs in SHOW and SCROLL and is held 0 in IDLE.
  - While phase = 1, digit k outputs FF if blink_mask[k] = 1.
  - Phase resets to 0 on rst and on any cmd_show or cmd_scroll.
- When undefined: blink_mask is ignored and no blink counter is instantiated.

Test Plan:
- Reset: rst high 2 cycles → o0..o7 = FF, busy = 0, wrap = 0.
- Static show: write buf0..3 = 1,2,3,4 with dp set on buf1, msg_len = 4, pulse cmd_show → o0 = 9F, o1 = 24, o2 = 0D, o3 = 99, o4..o7 = FF, busy = 1.
- Scroll wrap (STEP_CYCLES = 4, msg_len = 2, buf0 = 'H', buf1 = 'L', cmd_scroll):
  - Period P = 10, so after 4 steps o0 = FF, o6 = 91, o7 = E3.
  - After 10 steps (40 cycles) offset = 0 and wrap pulses for exactly 1 cycle.
- Write mid-scroll: during SCROLL, write buf0 = 0x11 → the digit showing v[0] changes to FD on the next output update; offset is unaffected.
- Command priority: assert cmd_stop, cmd_scroll and cmd_show together in SHOW → IDLE, outputs FF the next cycle. Then cmd_scroll with msg_len = 0 → len_q = 16, P = 24.
- Blink (macro defined, BLINK_CYCLES = 3, blink_mask = 8'h01, in SHOW): o0 alternates between its decoded value and FF every 3 cycles; o1..o7 are steady.

Source files
------------

// File: rtl/seg_scroller.sv
// seg_scroller: 16-entry message buffer with character decode and an 8-digit static or marquee window.
// Latency: o0..o7 are registered and reflect state, buffer and offset one clk edge later.
// Backpressure: none; writes and commands are accepted every cycle. Optional blink: define SEG_SCROLL_BLINK_EN.
module seg_scroller #(
    parameter int STEP_CYCLES  = 25000000,
    parameter int BLINK_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [5:0] wr_data,
    input  logic [3:0] msg_len,
    input  logic       cmd_show,
    input  logic       cmd_scroll,
    input  logic       cmd_stop,
    input  logic [7:0] blink_mask,
    output logic [7:0] o0,
    output logic [7:0] o1,
    output logic [7:0] o2,
    output logic [7:0] o3,
    output logic [7:0] o4,
    output logic [7:0] o5,
    output logic [7:0] o6,
    output logic [7:0] o7,
    output logic       busy,
    output logic       wrap
);

    localparam int PW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [5:0] BLANK_ENTRY = 6'b0_10000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHOW   = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    state_t        state;
    logic [5:0]    msg_buf [16];
    logic [4:0]    len_q;      // 1..16
    logic [4:0]    offset;     // 0..P-1, P <= 24
    logic [PW-1:0] presc;
    logic [7:0]    seg_q  [8];
    logic [7:0]    seg_nxt [8];
    logic [4:0]    len_sel;
    logic [4:0]    period;
    logic          blank_dig [8];

    // Character code to active-low {a,b,c,d,e,f,g,dp}; the dp bit applies to every code.
    function automatic logic [7:0] decode(input logic [5:0] ent);
        logic [7:0] pat;
        case (ent[4:0])
            5'h00: pat = 8'h03;
            5'h01: pat = 8'h9F;
            5'h02: pat = 8'h25;
            5'h03: pat = 8'h0D;
            5'h04: pat = 8'h99;
            5'h05: pat = 8'h49;
            5'h06: pat = 8'h41;
            5'h07: pat = 8'h1F;
            5'h08: pat = 8'h01;
            5'h09: pat = 8'h09;
            5'h0A: pat = 8'h11;
            5'h0B: pat = 8'hC1;
            5'h0C: pat = 8'h63;
            5'h0D: pat = 8'h85;
            5'h0E: pat = 8'h61;
            5'h0F: pat = 8'h71;
            5'h11: pat = 8'hFD;
            5'h12: pat = 8'h31;
            5'h13: pat = 8'hE3;
            5'h14: pat = 8'h91;
            5'h15: pat = 8'h83;
            5'h16: pat = 8'hF5;
            5'h17: pat = 8'hC5;
            default: pat = 8'hFF;
        endcase
        if (ent[5]) begin
            pat[0] = 1'b0;
        end
        return pat;
    endfunction

    // A zero length selects the full 16-entry buffer.
    assign len_sel = (msg_len == 4'd0) ? 5'd16 : {1'b0, msg_len};
    // Marquee period: message plus one window of trailing blanks.
    assign period  = len_q + 5'd8;
    assign busy    = (state != S_IDLE);

    // Command decode, state transitions, step prescaler, scroll offset and wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            len_q  <= 5'd16;
            offset <= 5'd0;
            presc  <= '0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (cmd_stop) begin
                state <= S_IDLE;
            end else if (cmd_scroll || cmd_show) begin
                state  <= cmd_scroll ? S_SCROLL : S_SHOW;
                len_q  <= len_sel;
                offset <= 5'd0;
                presc  <= '0;
            end else if (state == S_SCROLL) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (offset == period - 5'd1) begin
                        offset <= 5'd0;
                        wrap   <= 1'b1;
                    end else begin
                        offset <= offset + 5'd1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Message buffer; writes land in any state and are never blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                msg_buf[i] <= BLANK_ENTRY;
            end
        end else if (wr_en) begin
            msg_buf[wr_addr] <= wr_data;
        end
    end

`ifdef SEG_SCROLL_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] bcnt;
    logic          phase;

    // Blink phase generator; parked at phase 0 while idle and restarted by every display command.
    always_ff @(posedge clk) begin
        if (rst || cmd_stop || cmd_show || cmd_scroll || state == S_IDLE) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    // Per-digit blanking during the off phase of the blink.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            blank_dig[k] = phase && blink_mask[k];
        end
    end
`else
    logic unused_blink;
    assign unused_blink = (^blink_mask) ^ (BLINK_CYCLES > 0);

    // Blinking is compiled out; no digit is ever forced blank.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            blank_dig[k] = 1'b0;
        end
    end
`endif

    // Window selection: static prefix in SHOW, modulo-P virtual sequence in SCROLL.
    always_comb begin
        logic [4:0] idx;
        idx = 5'd0;
        for (int k = 0; k < 8; k++) begin
            seg_nxt[k] = 8'hFF;
            idx = offset + 5'(k);
            if (idx >= period) begin
                idx = idx - period;
            end
            case (state)
                S_SHOW: begin
                    if (5'(k) < len_q) begin
                        seg_nxt[k] = decode(msg_buf[k]);
                    end
                end
                S_SCROLL: begin
                    if (idx < len_q) begin
                        seg_nxt[k] = decode(msg_buf[idx[3:0]]);
                    end
                end
                default: seg_nxt[k] = 8'hFF;
            endcase
            if (blank_dig[k]) begin
                seg_nxt[k] = 8'hFF;
            end
        end
    end

    // Output registers: one cycle behind state, buffer and offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                seg_q[k] <= 8'hFF;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                seg_q[k] <= seg_nxt[k];
            end
        end
    end

    assign o0 = seg_q[0];
    assign o1 = seg_q[1];
    assign o2 = seg_q[2];
    assign o3 = seg_q[3];
    assign o4 = seg_q[4];
    assign o5 = seg_q[5];
    assign o6 = seg_q[6];
    assign o7 = seg_q[7];

endmodule

// File: tb/tb_seg_scroller.sv
// Directed bench for seg_scroller with STEP_CYCLES=4 and BLINK_CYCLES=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-decoded segment patterns.
module tb_seg_scroller;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [5:0] wr_data;
    logic [3:0] msg_len;
    logic       cmd_show;
    logic       cmd_scroll;
    logic       cmd_stop;
    logic [7:0] blink_mask;
    logic [7:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic       busy;
    logic       wrap;

    int n_cmp = 0;
    int n_err = 0;

    seg_scroller #(
        .STEP_CYCLES (4),
        .BLINK_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .msg_len   (msg_len),
        .cmd_show  (cmd_show),
        .cmd_scroll(cmd_scroll),
        .cmd_stop  (cmd_stop),
        .blink_mask(blink_mask),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .o4        (o4),
        .o5        (o5),
        .o6        (o6),
        .o7        (o7),
        .busy      (busy),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] o_all();
        return {o0, o1, o2, o3, o4, o5, o6, o7};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_wrap;
        int n_wrap;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
        cmd_show = 1'b0; cmd_scroll = 1'b0; cmd_stop = 1'b0; blink_mask = 8'h00;

        // Reset
        tick(); tick();
        check("reset_out", o_all(), {8{8'hFF}});
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_wrap", 64'(wrap), 64'd0);
        rst = 1'b0;

        // Buffer fill while idle: outputs stay blank
        wr(4'd0, 6'h01);
        wr(4'd1, 6'h22);
        wr(4'd2, 6'h03);
        wr(4'd3, 6'h04);
        tick();
        check("idle_blank", o_all(), {8{8'hFF}});

        // Static show of 4 characters, dp on digit 1
        msg_len = 4'd4; cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        check("show_busy", 64'(busy), 64'd1);
        tick();
        check("show_out", o_all(), {8'h9F, 8'h24, 8'h0D, 8'h99, {4{8'hFF}}});

        // msg_len change without a command is ignored
        msg_len = 4'd2;
        tick(); tick();
        check("len_ignored", o_all(), {8'h9F, 8'h24, 8'h0D, 8'h99, {4{8'hFF}}});

        // All three commands together: stop wins
        cmd_stop = 1'b1; cmd_scroll = 1'b1; cmd_show = 1'b1;
        tick();
        cmd_stop = 1'b0; cmd_scroll = 1'b0; cmd_show = 1'b0;
        check("prio_busy", 64'(busy), 64'd0);
        tick();
        check("prio_out", o_all(), {8{8'hFF}});

        // Scroll 'H','L' with P = 10
        wr(4'd0, 6'h14);
        wr(4'd1, 6'h13);
        msg_len = 4'd2; cmd_scroll = 1'b1;
        tick();                       // edge N
        cmd_scroll = 1'b0;
        tick();                       // N+1: offset 0 visible
        check("scroll_off0", o_all(), {8'h91, 8'hE3, {6{8'hFF}}});
        check("scroll_busy", 64'(busy), 64'd1);
        repeat (16) tick();           // N+17: offset 4 visible
        check("scroll_off4", o_all(), {{6{8'hFF}}, 8'h91, 8'hE3});

        // Mid-scroll write of '-' into entry 0
        wr(4'd0, 6'h11);              // N+18
        check("midwr_pre", o_all(), {{6{8'hFF}}, 8'h91, 8'hE3});
        tick();                       // N+19
        check("midwr_post", o_all(), {{6{8'hFF}}, 8'hFD, 8'hE3});
        tick(); tick();               // N+21: offset 5 visible
        check("midwr_off5", o_all(), {{5{8'hFF}}, 8'hFD, 8'hE3, 8'hFF});

        // Wrap after 10 steps (edge N+40)
        repeat (18) tick();           // N+39
        check("wrap_before", 64'(wrap), 64'd0);
        tick();                       // N+40
        check("wrap_pulse", 64'(wrap), 64'd1);
        tick();                       // N+41
        check("wrap_after", 64'(wrap), 64'd0);
        check("wrap_frame", o_all(), {8'hFD, 8'hE3, {6{8'hFF}}});

        // Restart scroll with msg_len = 0 -> 16 entries, P = 24, wrap after 96 cycles
        msg_len = 4'd0; cmd_scroll = 1'b1;
        tick();                       // edge M
        cmd_scroll = 1'b0;
        first_wrap = 0;
        n_wrap = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 1) begin
                check("len16_frame", o_all(), {8'hFD, 8'hE3, 8'h0D, 8'h99, {4{8'hFF}}});
            end
            if (wrap) begin
                n_wrap++;
                if (first_wrap == 0) first_wrap = i;
            end
        end
        check("len16_wrap_at", 64'(first_wrap), 64'd96);
        check("len16_wrap_cnt", 64'(n_wrap), 64'd1);

        // Reset beats command and write in the same cycle
        rst = 1'b1; cmd_scroll = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 6'h01;
        tick();
        rst = 1'b0; cmd_scroll = 1'b0; wr_en = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        tick();
        check("rst_mid_out", o_all(), {8{8'hFF}});
        msg_len = 4'd8; cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        tick();
        check("rst_buf_clear", o_all(), {8{8'hFF}});

        // Decode coverage incl. dp on an undefined code
        wr(4'd0, 6'h38);
        wr(4'd1, 6'h1F);
        wr(4'd2, 6'h17);
        wr(4'd3, 6'h16);
        wr(4'd4, 6'h12);
        wr(4'd5, 6'h15);
        wr(4'd6, 6'h0E);
        wr(4'd7, 6'h0B);
        tick();
        check("decode_misc", o_all(), {8'hFE, 8'hFF, 8'hC5, 8'hF5, 8'h31, 8'h83, 8'h61, 8'hC1});

        // Length 7: last digit blank
        msg_len = 4'd7; cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        tick();
        check("show_len7", o_all(), {8'hFE, 8'hFF, 8'hC5, 8'hF5, 8'h31, 8'h83, 8'h61, 8'hFF});

`ifdef SEG_SCROLL_BLINK_EN
        // Blink on digit 0 with half-period 3
        blink_mask = 8'h01; msg_len = 4'd8; cmd_show = 1'b1;
        tick();
        cmd_show = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("blink_o0", 64'(o0), (((i - 1) / 3) % 2 == 1) ? 64'hFF : 64'hFE);
            check("blink_o1", 64'(o1), 64'hFF);
        end
`else
        // Blink compiled out: mask has no effect
        blink_mask = 8'hFF;
        repeat (7) tick();
        check("noblink", o_all(), {8'hFE, 8'hFF, 8'hC5, 8'hF5, 8'h31, 8'h83, 8'h61, 8'hFF});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
